// File: rtl/libhdl_stream_pkg.sv
// Shared helpers for the libhdl stream width converters: lane index width
// and lane placement within a packed beat.
package libhdl_stream_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++)
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    return r;
  endfunction

  function automatic int unsigned lane_w(input int unsigned ratio);
    return (clog2(ratio) < 1) ? 1 : clog2(ratio);
  endfunction

  // Arrival order k maps to lane k, or mirrored when the first word goes on top.
  function automatic int unsigned lane_pos(input int unsigned k,
                                           input int unsigned ratio,
                                           input bit msb_first);
    return msb_first ? (ratio - 1 - k) : k;
  endfunction

endpackage

// File: rtl/libhdl_stream_packer.sv
// Packs RATIO narrow valid/ready words into one wide output beat.
// Optional early-close support (i_wlast/o_rlast/o_rkeep): LIBHDL_STREAM_PACKER_LAST_EN.
module libhdl_stream_packer
  import libhdl_stream_pkg::*;
#(
  parameter int unsigned DATA_LEN  = 32,
  parameter int unsigned RATIO     = 4,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  output logic                         o_wrdy,
  input  logic                         i_wvld,
  input  logic [DATA_LEN-1:0]          i_wdat,
`ifdef LIBHDL_STREAM_PACKER_LAST_EN
  input  logic                         i_wlast,
  output logic                         o_rlast,
  output logic [RATIO-1:0]             o_rkeep,
`endif
  input  logic                         i_rrdy,
  output logic                         o_rvld,
  output logic [DATA_LEN*RATIO-1:0]    o_rdat,
  output logic [lane_w(RATIO)-1:0]     o_lane
);

  localparam int unsigned       LANE_W    = lane_w(RATIO);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  logic [DATA_LEN-1:0]       acc [RATIO-1];
  logic [DATA_LEN*RATIO-1:0] beat;
  logic                      close_beat;
  logic                      in_xfer;
  logic                      out_xfer;

`ifdef LIBHDL_STREAM_PACKER_LAST_EN
  logic [RATIO-1:0] keep;
  assign close_beat = (o_lane == LAST_LANE) || i_wlast;
`else
  assign close_beat = (o_lane == LAST_LANE);
`endif

  assign o_wrdy   = !i_rst && (!close_beat || !o_rvld || i_rrdy);
  assign in_xfer  = i_wvld && o_wrdy;
  assign out_xfer = o_rvld && i_rrdy;

  // Accumulator is kept in arrival order and cleared after every beat, so
  // lanes not yet filled contribute zeros to an early-closed beat.
  always_comb begin
    beat = '0;
    for (int unsigned k = 0; k < RATIO - 1; k++)
      beat[lane_pos(k, RATIO, MSB_FIRST)*DATA_LEN +: DATA_LEN] = acc[k];
    for (int unsigned k = 0; k < RATIO; k++)
      if (o_lane == LANE_W'(k))
        beat[lane_pos(k, RATIO, MSB_FIRST)*DATA_LEN +: DATA_LEN] = i_wdat;
  end

`ifdef LIBHDL_STREAM_PACKER_LAST_EN
  always_comb begin
    keep = '0;
    for (int unsigned k = 0; k < RATIO; k++)
      if (LANE_W'(k) <= o_lane) keep[lane_pos(k, RATIO, MSB_FIRST)] = 1'b1;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rvld <= 1'b0;
      o_rdat <= '0;
      o_lane <= '0;
      for (int unsigned k = 0; k < RATIO - 1; k++) acc[k] <= '0;
`ifdef LIBHDL_STREAM_PACKER_LAST_EN
      o_rlast <= 1'b0;
      o_rkeep <= '0;
`endif
    end else if (in_xfer && close_beat) begin
      o_rdat <= beat;
      o_rvld <= 1'b1;
      o_lane <= '0;
      for (int unsigned k = 0; k < RATIO - 1; k++) acc[k] <= '0;
`ifdef LIBHDL_STREAM_PACKER_LAST_EN
      o_rlast <= i_wlast;
      o_rkeep <= keep;
`endif
    end else begin
      if (out_xfer) o_rvld <= 1'b0;
      if (in_xfer) begin
        for (int unsigned k = 0; k < RATIO - 1; k++)
          if (o_lane == LANE_W'(k)) acc[k] <= i_wdat;
        o_lane <= o_lane + LANE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_libhdl_stream_packer.sv
// Directed self-checking bench for libhdl_stream_packer (default, MSB_FIRST=1
// and RATIO=3 instances; early-close checks when LIBHDL_STREAM_PACKER_LAST_EN is set).
module tb_libhdl_stream_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         wvld, wrdy, rrdy, rvld;
  logic [31:0]  wdat;
  logic [127:0] rdat;
  logic [1:0]   lane;

  logic         m_wvld, m_wrdy, m_rvld;
  logic [31:0]  m_wdat;
  logic [127:0] m_rdat;
  logic [1:0]   m_lane;

  logic         t_wvld, t_wrdy, t_rvld;
  logic [31:0]  t_wdat;
  logic [95:0]  t_rdat;
  logic [1:0]   t_lane;

`ifdef LIBHDL_STREAM_PACKER_LAST_EN
  logic       wlast, rlast, m_rlast, t_rlast;
  logic [3:0] rkeep, m_rkeep;
  logic [2:0] t_rkeep;
`endif

  int checks   = 0;
  int failures = 0;

  libhdl_stream_packer #(.DATA_LEN(32), .RATIO(4), .MSB_FIRST(1'b0)) u_dut (
    .i_clk(clk), .i_rst(rst), .o_wrdy(wrdy), .i_wvld(wvld), .i_wdat(wdat),
`ifdef LIBHDL_STREAM_PACKER_LAST_EN
    .i_wlast(wlast), .o_rlast(rlast), .o_rkeep(rkeep),
`endif
    .i_rrdy(rrdy), .o_rvld(rvld), .o_rdat(rdat), .o_lane(lane)
  );

  libhdl_stream_packer #(.DATA_LEN(32), .RATIO(4), .MSB_FIRST(1'b1)) u_msb (
    .i_clk(clk), .i_rst(rst), .o_wrdy(m_wrdy), .i_wvld(m_wvld), .i_wdat(m_wdat),
`ifdef LIBHDL_STREAM_PACKER_LAST_EN
    .i_wlast(1'b0), .o_rlast(m_rlast), .o_rkeep(m_rkeep),
`endif
    .i_rrdy(1'b1), .o_rvld(m_rvld), .o_rdat(m_rdat), .o_lane(m_lane)
  );

  libhdl_stream_packer #(.DATA_LEN(32), .RATIO(3), .MSB_FIRST(1'b0)) u_r3 (
    .i_clk(clk), .i_rst(rst), .o_wrdy(t_wrdy), .i_wvld(t_wvld), .i_wdat(t_wdat),
`ifdef LIBHDL_STREAM_PACKER_LAST_EN
    .i_wlast(1'b0), .o_rlast(t_rlast), .o_rkeep(t_rkeep),
`endif
    .i_rrdy(1'b1), .o_rvld(t_rvld), .o_rdat(t_rdat), .o_lane(t_lane)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] beat1;
    rst = 1'b1; wvld = 1'b0; wdat = '0; rrdy = 1'b1;
    m_wvld = 1'b0; m_wdat = '0; t_wvld = 1'b0; t_wdat = '0;
`ifdef LIBHDL_STREAM_PACKER_LAST_EN
    wlast = 1'b0;
`endif
    cyc(); cyc();
    chk("rst_rvld", rvld, 0);
    chk("rst_rdat", rdat, 0);
    chk("rst_lane", lane, 0);
    chk("rst_wrdy", wrdy, 0);
    rst = 1'b0; #1;
    chk("post_rst_wrdy", wrdy, 1);

    // Partial beat discarded by a mid-beat reset
    wvld = 1'b1; wdat = 32'hdead0001; cyc();
    wdat = 32'hdead0002; cyc();
    chk("pre_rst_lane", lane, 2);
    rst = 1'b1; wvld = 1'b0; cyc();
    rst = 1'b0;
    chk("mid_rst_lane", lane, 0);
    chk("mid_rst_rvld", rvld, 0);
    wvld = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wdat = 32'h11 * i;
      cyc();
    end
    wvld = 1'b0;
    chk("reset_beat_rdat", rdat, 128'h00000044_00000033_00000022_00000011);
    chk("reset_beat_rvld", rvld, 1);
    chk("reset_beat_lane", lane, 0);
    cyc();
    chk("out_clear_rvld", rvld, 0);

    // Continuous streaming, output always ready
    for (int i = 1; i <= 12; i++) begin
      wvld = 1'b1; wdat = 32'(i); #1;
      chk("cont_wrdy", wrdy, 1);
      cyc();
      chk("cont_lane", lane, 128'(i % 4));
      chk("cont_rvld", rvld, 128'(i % 4 == 0));
      if (i % 4 == 0)
        chk("cont_rdat", rdat, {32'(i), 32'(i - 1), 32'(i - 2), 32'(i - 3)});
    end
    wvld = 1'b0; cyc();
    chk("cont_drain_rvld", rvld, 0);

    // Back-pressure: fill continues until the final lane, then stalls
    wvld = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wdat = 32'h100 + 32'(i);
      cyc();
    end
    beat1 = 128'h00000104_00000103_00000102_00000101;
    rrdy = 1'b0;
    chk("bp_beat1_rvld", rvld, 1);
    for (int i = 1; i <= 3; i++) begin
      wdat = 32'h200 + 32'(i); #1;
      chk("bp_wrdy_fill", wrdy, 1);
      cyc();
    end
    chk("bp_lane", lane, 3);
    chk("bp_hold_rdat", rdat, beat1);
    wdat = 32'h204; #1;
    chk("bp_wrdy_stall", wrdy, 0);
    cyc(); cyc();
    chk("bp_hold2_rdat", rdat, beat1);
    chk("bp_hold2_rvld", rvld, 1);
    chk("bp_hold2_lane", lane, 3);
    rrdy = 1'b1; #1;
    chk("bp_wrdy_release", wrdy, 1);
    cyc();
    chk("bp_nobubble_rvld", rvld, 1);
    chk("bp_beat2_rdat", rdat, 128'h00000204_00000203_00000202_00000201);
    chk("bp_beat2_lane", lane, 0);
    wvld = 1'b0; cyc();
    chk("bp_drain_rvld", rvld, 0);

    // MSB_FIRST instance
    m_wvld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_wdat = 32'hA + 32'(i);
      cyc();
    end
    m_wvld = 1'b0;
    chk("msb_rdat", m_rdat, 128'h0000000A_0000000B_0000000C_0000000D);
    chk("msb_rvld", m_rvld, 1);

    // RATIO=3 instance
    chk("r3_lane_init", t_lane, 0);
    t_wvld = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      t_wdat = 32'(i);
      cyc();
      chk("r3_lane", t_lane, 128'(i % 3));
      if (i % 3 == 0) begin
        chk("r3_rvld", t_rvld, 1);
        chk("r3_rdat", t_rdat, 128'({32'(i), 32'(i - 1), 32'(i - 2)}));
      end
    end
    t_wvld = 1'b0;

`ifdef LIBHDL_STREAM_PACKER_LAST_EN
    // Early close on the second lane, then a full beat
    cyc();
    wvld = 1'b1; wdat = 32'h5; wlast = 1'b0; cyc();
    wdat = 32'h6; wlast = 1'b1; cyc();
    wvld = 1'b0; wlast = 1'b0;
    chk("last_rdat", rdat, 128'h00000000_00000000_00000006_00000005);
    chk("last_rkeep", rkeep, 4'b0011);
    chk("last_rlast", rlast, 1);
    chk("last_lane", lane, 0);
    wvld = 1'b1;
    for (int i = 7; i <= 10; i++) begin
      wdat = 32'(i);
      cyc();
    end
    wvld = 1'b0;
    chk("full_rdat", rdat, 128'h0000000A_00000009_00000008_00000007);
    chk("full_rkeep", rkeep, 4'b1111);
    chk("full_rlast", rlast, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
